// File: rtl/vend_dispense_responder_if.sv
// rtl/vend_dispense_responder_if.sv - controller-side vend handshake bundle
interface vend_dispense_responder_if #(
  parameter int SLOT_W = 4
);
  logic              req;
  logic [SLOT_W-1:0] slot;
  logic              ack;
  logic              busy;
  logic              done;
  logic              fault;
  logic [7:0]        err_count;

  modport master (
    output req, slot,
    input  ack, busy, done, fault, err_count
  );

  modport slave (
    input  req, slot,
    output ack, busy, done, fault, err_count
  );
endinterface

// File: rtl/vend_dispense_responder.sv
// rtl/vend_dispense_responder.sv - vend start responder: spins the slot motor, watches the drop sensor
module vend_dispense_responder #(
  parameter int NUM_SLOTS      = 10,
  parameter int SLOT_W         = 4,
  parameter int MOTOR_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  vend_dispense_responder_if.slave   bus,
  input  logic                       drop_sensor_i,
  output logic                       motor_en_o,
  output logic [SLOT_W-1:0]          motor_sel_o
);

  // One counter serves both the spin phase and the drop timeout.
  localparam int CNT_MAX = (MOTOR_CYCLES > TIMEOUT_CYCLES) ? MOTOR_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0]  SPIN_LAST  = CNT_W'(MOTOR_CYCLES - 1);
  localparam logic [CNT_W-1:0]  WAIT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  // One extra bit so NUM_SLOTS == 2^SLOT_W is still representable.
  localparam logic [SLOT_W:0]   SLOT_LIMIT = (SLOT_W + 1)'(NUM_SLOTS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPIN,
    S_WAIT_DROP,
    S_DONE,
    S_FAULT,
    S_WAIT_RELEASE
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              drop_seen_q;
  logic              ack_q;
  logic              busy_q;
  logic              motor_en_q;
  logic [SLOT_W-1:0] motor_sel_q;
  logic              done_q;
  logic              fault_q;
  logic [7:0]        err_count_q;

  logic              drop_seen_d;
  logic [7:0]        err_count_d;
  logic              slot_valid;

  // A drop in the current spin cycle counts together with earlier ones.
  assign drop_seen_d = drop_seen_q | drop_sensor_i;
  assign err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
  assign slot_valid  = ({1'b0, bus.slot} < SLOT_LIMIT);

  // Vend sequencer: every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      drop_seen_q <= 1'b0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      motor_en_q  <= 1'b0;
      motor_sel_q <= '0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.req) begin
            busy_q <= 1'b1;
            if (slot_valid) begin
              state_q     <= S_SPIN;
              motor_sel_q <= bus.slot;
              ack_q       <= 1'b1;
              motor_en_q  <= 1'b1;
              cnt_q       <= '0;
              drop_seen_q <= 1'b0;
            end else begin
              state_q     <= S_FAULT;
              fault_q     <= 1'b1;
              err_count_q <= err_count_d;
            end
          end
        end
        S_SPIN: begin
          if (cnt_q == SPIN_LAST) begin
            motor_en_q <= 1'b0;
            cnt_q      <= '0;
            if (drop_seen_d) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_WAIT_DROP;
            end
          end else begin
            cnt_q       <= cnt_q + 1'b1;
            drop_seen_q <= drop_seen_d;
          end
        end
        S_WAIT_DROP: begin
          // Checking the sensor first makes a drop in the last cycle a success.
          if (drop_sensor_i) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if (cnt_q == WAIT_LAST) begin
            state_q     <= S_FAULT;
            fault_q     <= 1'b1;
            err_count_q <= err_count_d;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE, S_FAULT: begin
          state_q <= S_WAIT_RELEASE;
        end
        S_WAIT_RELEASE: begin
          if (!bus.req) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          busy_q     <= 1'b0;
          motor_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fault     = fault_q;
  assign bus.err_count = err_count_q;
  assign motor_en_o    = motor_en_q;
  assign motor_sel_o   = motor_sel_q;

endmodule

// File: tb/tb_vend_dispense_responder.sv
// tb/tb_vend_dispense_responder.sv - scoreboard bench for vend_dispense_responder
module tb_vend_dispense_responder;

  localparam int NUM_SLOTS = 10;
  localparam int M         = 8;
  localparam int T         = 64;

  logic       clk;
  logic       rst;
  logic       drop_sensor;
  logic       motor_en;
  logic [3:0] motor_sel;

  vend_dispense_responder_if #(.SLOT_W(4)) bus ();

  vend_dispense_responder #(
    .NUM_SLOTS(NUM_SLOTS), .SLOT_W(4), .MOTOR_CYCLES(M), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .drop_sensor_i(drop_sensor),
    .motor_en_o(motor_en),
    .motor_sel_o(motor_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int slot;
    bit is_done;
    int start;
    int lat;
    int err;
    int motor;
    int ack;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   err_model = 0;

  int   acc_ack = 0;
  int   acc_motor = 0;
  int   acc_sel_bad = 0;
  int   acc_overlap = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference outcome from the vend rules: first drop cycle decides, counted from acceptance.
  function automatic exp_t model(input int slot, input int lo);
    exp_t e;
    e.slot = slot;
    if (slot >= NUM_SLOTS) begin
      e.is_done = 0; e.lat = 1; e.motor = 0; e.ack = 0;
    end else begin
      e.motor = M; e.ack = 1;
      if (lo >= 1 && lo <= M) begin
        e.is_done = 1; e.lat = M + 1;
      end else if (lo > M && lo <= M + T) begin
        e.is_done = 1; e.lat = lo + 1;
      end else begin
        e.is_done = 0; e.lat = M + T + 1;
      end
    end
    return e;
  endfunction

  // Monitor: accumulates per-transaction activity and scores it on done/fault.
  always @(negedge clk) begin
    if (rst) begin
      acc_ack = 0; acc_motor = 0; acc_sel_bad = 0; acc_overlap = 0;
    end else begin
      if (bus.ack) acc_ack++;
      if (motor_en) begin
        acc_motor++;
        if (q.size() == 0 || int'(motor_sel) != q[0].slot) acc_sel_bad++;
      end
      if (bus.done && bus.fault) acc_overlap++;
      if (bus.done || bus.fault) begin
        if (q.size() == 0) begin
          chk("unexpected_event", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("kind_done", int'(bus.done), int'(e.is_done));
          chk("event_cycle", cyc - e.start, e.lat);
          chk("err_count", int'(bus.err_count), e.err);
          chk("ack_cycles", acc_ack, e.ack);
          chk("motor_cycles", acc_motor, e.motor);
          chk("motor_sel_bad", acc_sel_bad, 0);
          chk("busy_at_event", int'(bus.busy), 1);
          chk("done_fault_overlap", acc_overlap, 0);
        end
        acc_ack = 0; acc_motor = 0; acc_sel_bad = 0; acc_overlap = 0;
      end
    end
  end

  // Drive one vend: drop_sensor high over cycles [lo,hi] after acceptance (lo=0: never),
  // req pulled low for cycle 'glitch' (0: never), req held 'hold' cycles past the event.
  task automatic run_txn(input bit skip_start, input int slot, input int lo, input int hi,
                         input int glitch, input int hold);
    exp_t e;
    if (!skip_start) begin
      @(posedge clk); #1;
      bus.req = 1'b1; bus.slot = 4'(slot); drop_sensor = 1'b0;
    end
    e = model(slot, lo);
    e.start = cyc;
    if (!e.is_done && err_model < 255) err_model++;
    e.err = err_model;
    q.push_back(e);
    for (int k = 1; k <= e.lat + hold; k++) begin
      @(posedge clk); #1;
      drop_sensor = (lo != 0 && k >= lo && k <= hi);
      bus.req = (k != glitch);
      if (k == 2) bus.slot = 4'($urandom_range(0, 15));
    end
    bus.req = 1'b0; drop_sensor = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("busy_after_release", int'(bus.busy), 0);
  endtask

  initial begin
    rst = 1'b1; bus.req = 1'b0; bus.slot = '0; drop_sensor = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ack", int'(bus.ack), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_motor_en", int'(motor_en), 0);
    chk("rst_motor_sel", int'(motor_sel), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_fault", int'(bus.fault), 0);
    chk("rst_err_count", int'(bus.err_count), 0);

    // Directed cases.
    run_txn(0, 3, 11, 11, 0, 3);       // drop on 3rd WAIT_DROP cycle
    run_txn(0, 12, 0, 0, 0, 20);       // invalid slot, req held long
    run_txn(0, 0, 2, 2, 0, 2);         // drop during spin
    run_txn(0, 6, M + T, M + T, 0, 1); // drop on last timeout cycle wins
    run_txn(0, 6, M + T + 1, M + T + 2, 0, 1); // drop too late
    run_txn(0, 9, 30, 31, 20, 2);      // req glitch during WAIT_DROP

    // Reset in the middle of the spin phase, req kept high throughout.
    @(posedge clk); #1;
    bus.req = 1'b1; bus.slot = 4'd4;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1; err_model = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_motor_en", int'(motor_en), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_err_count", int'(bus.err_count), 0);
    run_txn(1, 4, 3, 3, 0, 2);

    // Randomized vends.
    for (int n = 0; n < 40; n++) begin
      int slot, mode, lo, hi, glitch;
      slot = $urandom_range(0, 15);
      mode = $urandom_range(0, 3);
      case (mode)
        0: lo = 0;
        1: lo = $urandom_range(1, M);
        2: lo = $urandom_range(M + 1, M + T);
        default: lo = $urandom_range(M + T + 1, M + T + 8);
      endcase
      hi = lo + $urandom_range(0, 3);
      glitch = 0;
      if (slot < NUM_SLOTS && (lo == 0 || lo >= 13) && $urandom_range(0, 1) == 1)
        glitch = M + 1 + $urandom_range(0, 2);
      run_txn(0, slot, lo, hi, glitch, $urandom_range(1, 4));
    end

    // Timeout storm to saturate the fault counter.
    for (int n = 0; n < 260; n++) run_txn(0, 5, 0, 0, 0, 1);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("queue_empty", q.size(), 0);
    chk("err_saturated", int'(bus.err_count), 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_dispense_responder.md
Name: vend_dispense_responder

Overview:
- Responder end of the vend start handshake. The controller FSM raises a sticky `req` (IDLE→ACTIVE) together with a slot number; this block accepts it and drives the spiral motor for that slot.
- It then watches the drop sensor and reports `done` or `fault`.
- It sits between the vending controller FSM and the motor/sensor I/O. It waits for `req` to be released before it accepts another transaction.

Parameters:
- NUM_SLOTS, 10: number of valid product slots (0..NUM_SLOTS-1).
- SLOT_W, 4: width of the slot index; must satisfy 2^SLOT_W >= NUM_SLOTS.
- MOTOR_CYCLES, 8: exact number of cycles `motor_en` is held high per vend (>=1).
- TIMEOUT_CYCLES, 64: maximum cycles spent in WAIT_DROP before a fault is declared (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  1  vend request level from the controller; sticky until the controller resets or releases it.
- slot  in  SLOT_W  requested slot; sampled only on acceptance.
- drop_sensor  in  1  product-drop detector, synchronous to clk, high while a product falls.
- ack  out  1  one-cycle pulse: request accepted and motor started.
- busy  out  1  high in every state except IDLE.
- motor_en  out  1  motor drive.
- motor_sel  out  SLOT_W  latched slot driven to the motor mux.
- done  out  1  one-cycle pulse: vend succeeded.
- fault  out  1  one-cycle pulse: invalid slot or drop timeout.
- err_count  out  8  saturating count of faults since reset.

Behaviour:

Registers and reset:
- All outputs are registered.
- On rst=1 at a clock edge, the next values are: state=IDLE, ack=0, busy=0, motor_en=0, motor_sel=0, done=0, fault=0, err_count=0, internal counter=0, drop_seen=0.
- rst has priority over every other input, including mid-transaction. The motor is off the cycle after rst is sampled.

States: IDLE, SPIN, WAIT_DROP, DONE, FAULT, WAIT_RELEASE.

IDLE:
- req=1 and slot<NUM_SLOTS → SPIN. In the same edge: latch motor_sel=slot, set ack=1 and motor_en=1, clear cnt and drop_seen.
- req=1 and slot>=NUM_SLOTS → FAULT. ack stays 0 and the motor is never enabled.
- req=0 → stay in IDLE.

SPIN:
- motor_en=1 for exactly MOTOR_CYCLES cycles. cnt counts 0..MOTOR_CYCLES-1.
- ack is high only during the first SPIN cycle.
- drop_sensor=1 in any SPIN cycle sets drop_seen.
- On the last SPIN cycle: drop_seen (including a drop in that cycle) → DONE; otherwise → WAIT_DROP with cnt cleared. motor_en=0 from the next cycle.

WAIT_DROP:
- drop_sensor=1 sampled → DONE on the next edge.
- After TIMEOUT_CYCLES cycles with no drop → FAULT.
- A drop in the final timeout cycle counts as success: success wins over timeout.

DONE and FAULT:
- DONE: done=1 for one cycle, then → WAIT_RELEASE.
- FAULT: fault=1 for one cycle, err_count increments (holds at 255), then → WAIT_RELEASE.

WAIT_RELEASE:
- Stay while req=1; req=0 → IDLE.
- A req that stays high never starts a second vend.

Other rules:
- req dropping mid-transaction (SPIN/WAIT_DROP) is ignored; the transaction completes normally.
- slot changing after acceptance has no effect.
- done and fault are never high in the same cycle.
- motor_en is never high outside SPIN.
- Latency, req rise to motor_en: 1 cycle.
- Minimum transaction to done: MOTOR_CYCLES+1 cycles after acceptance.

Test Plan:
- rst=1 for 2 cycles, then req=1, slot=3, drop_sensor=1 on 3rd cycle after WAIT_DROP entry → ack one cycle, motor_en high exactly 8 cycles with motor_sel=3, done one cycle, err_count=0, busy stays high until req=0, then IDLE.
- req=1, slot=12 (>=10) → no ack, motor_en never high, fault one cycle next cycle, err_count=1; req held high 20 cycles → no further activity.
- req=1, slot=5, drop_sensor never high → motor 8 cycles, then 64 WAIT_DROP cycles, fault pulse, err_count increments. Repeat 260 times → err_count saturates at 255.
- drop_sensor pulsed during SPIN cycle 2, slot=0 → motor still runs full 8 cycles, done the cycle after SPIN, WAIT_DROP never entered.
- rst asserted during SPIN cycle 4 → next cycle motor_en=0, busy=0, err_count=0. With req held high, a new vend starts the cycle after rst deasserts.
- Drop on the 64th WAIT_DROP cycle → done (not fault). Drop on cycle 65 → fault already issued and drop ignored. req toggled low for 1 cycle during WAIT_DROP → transaction unaffected.
